branch_predict_ctrl: RTL and testbench
======================================

Name: branch_predict_ctrl

Overview:
- Parametrised successor to the D-stage branch mux select logic for the 5-stage MIPS pipeline.
- Replaces the single static prediction bit with a branch history table (BHT) of 2-bit saturating counters, indexed by PC.
- Predicts in D, resolves in E, updates the table on resolve, and drives the PC mux select, including mispredict recovery.
- Also drives a D-stage flush request and keeps a saturating mispredict counter for performance monitoring.

Parameters:
- PC_W, 32, program counter width.
- IDX_W, 6, BHT index width. The table has 2^IDX_W entries, indexed by PC[IDX_W+1:2].
- MISS_W, 16, width of the mispredict performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- branchD  in  1  instruction in D is a conditional branch.
- pcD  in  PC_W  PC of the instruction in D.
- stallD  in  1  D is stalled; suppresses the D-stage prediction select.
- branchE  in  1  instruction in E is a conditional branch being resolved.
- pcE  in  PC_W  PC of the branch in E.
- takenE  in  1  actual branch outcome computed in E.
- predtakenE  in  1  prediction made in D for this branch, carried down the pipe.
- predtakenD  out  1  prediction for the branch in D; pipelined by the datapath into predtakenE.
- brmuxsel  out  2  PC source select.
- flushD  out  1  squash the D and F instructions (wrong path).
- mispredictE  out  1  branch in E was mispredicted.
- misscount  out  MISS_W  saturating count of mispredicts.
- clr_misscount  in  1  synchronous clear of misscount.

Behaviour:
- brmuxsel encoding:
  - 0 = PC+4 (sequential).
  - 1 = D-stage branch target (predicted taken).
  - 2 = recovery to pcE+4 (predicted taken, actually not taken).
  - 3 = recovery to E-stage branch target (predicted not taken, actually taken).
- Table entries are 2-bit counters, 00 to 11. predtakenD = MSB of the entry at index pcD[IDX_W+1:2], qualified by branchD. predtakenD is 0 when branchD=0.
- Lookup is combinational. An update writes at the rising edge.
  - No bypass: if D looks up the same index E updates in that cycle, D sees the pre-update value.
- Update applies when branchE=1 at the clock edge, to index pcE[IDX_W+1:2]:
  - takenE=1: increment, saturating at 11.
  - takenE=0: decrement, saturating at 00.
  - All other entries hold.
- mispredictE = branchE & (takenE ^ predtakenE). Combinational, same cycle.
- Select priority, highest first:
  1. mispredictE=1: brmuxsel = takenE ? 3 : 2, and flushD=1. This overrides any D prediction in the same cycle.
  2. branchD & ~stallD & predtakenD: brmuxsel=1, flushD=0.
  3. Otherwise: brmuxsel=0, flushD=0.
- flushD is asserted only on a mispredict. Predicted-taken redirect in D costs no flush beyond the F instruction, which the datapath already handles.
- misscount:
  - Increments by 1 on each clock edge with mispredictE=1.
  - Saturates at all-ones and does not wrap.
  - clr_misscount has priority over increment: clear and mispredict in the same cycle gives 0.
- Reset, asynchronous and active-low:
  - All BHT entries = 01 (weakly not taken).
  - misscount = 0.
- Outputs are combinational from the table and inputs. During reset they are therefore 0: predtakenD=0, brmuxsel=0, flushD=0, mispredictE=0.
- Reset asserted mid-operation: the table reinitialises immediately. Any pending update is dropped.
- stallD does not block E-stage updates or recovery.
- Aliasing: different PCs with equal index bits share an entry. This is accepted behaviour, with no tag check.

Decomposition:
- Shared package pipe_pkg holds:
  - brmuxsel encodings BRSEL_SEQ=0, BRSEL_PRED=1, BRSEL_RECNT=2, BRSEL_RECT=3.
  - CTR_RESET=2'b01.
  - The 2-bit counter typedef.
- One sub-module: branch_hist_table. It contains the counter array, the combinational read port and the saturating update port, parameterised by IDX_W.
- Select logic and misscount live in the top.

Test Plan:
- Reset, then branchD=1, pcD=0x40 -> predtakenD=0, brmuxsel=0. Entry 16 reads 01.
- Two resolves branchE=1, pcE=0x40, takenE=1, predtakenE=0 -> mispredictE=1, brmuxsel=3, flushD=1 each time, misscount=2. Next lookup at 0x40 gives predtakenD=1, brmuxsel=1.
- Four further taken resolves at 0x40 -> entry saturates at 11. One not-taken resolve gives 10, and predtakenD stays 1.
- Same cycle: mispredict in E (takenE=0, predtakenE=1) with branchD predicted taken -> brmuxsel=2, flushD=1. The D prediction is ignored.
- Same-index lookup and update, with pcD=pcE=0x80 and entry 01, takenE=1 -> predtakenD=0 that cycle, 1 the next.
- misscount at MISS_W all-ones plus mispredict -> holds all-ones. clr_misscount with mispredict -> 0. Assert rst_n low mid-run -> all entries 01 asynchronously.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: PC mux select encodings and the 2-bit
// saturating counter used by the branch history table.
package pipe_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_RESET = 2'b01;

  localparam logic [1:0] BRSEL_SEQ   = 2'd0;
  localparam logic [1:0] BRSEL_PRED  = 2'd1;
  localparam logic [1:0] BRSEL_RECNT = 2'd2;
  localparam logic [1:0] BRSEL_RECT  = 2'd3;

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    if (taken) begin
      if (c != 2'b11) n = c + 2'd1;
    end else begin
      if (c != 2'b00) n = c - 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_hist_table.sv
// Branch history table: 2^IDX_W two-bit saturating counters with one
// combinational read port and one clocked update port (no read bypass).
module branch_hist_table
  import pipe_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr_t             rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int DEPTH = 1 << IDX_W;

  ctr_t tbl [DEPTH];

  assign rd_ctr = tbl[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= CTR_RESET;
    end else if (wr_en) begin
      tbl[wr_idx] <= ctr_next(tbl[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// D-stage branch prediction and E-stage resolve/recovery: drives the PC mux
// select and D flush, trains the BHT, and counts mispredicts.
module branch_predict_ctrl
  import pipe_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int IDX_W  = 6,
  parameter int MISS_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branchD,
  input  logic [PC_W-1:0]   pcD,
  input  logic              stallD,
  input  logic              branchE,
  input  logic [PC_W-1:0]   pcE,
  input  logic              takenE,
  input  logic              predtakenE,
  output logic              predtakenD,
  output logic [1:0]        brmuxsel,
  output logic              flushD,
  output logic              mispredictE,
  output logic [MISS_W-1:0] misscount,
  input  logic              clr_misscount
);

  ctr_t rd_ctr;

  // Word-aligned PCs: the two low bits and the bits above the index are
  // not used for lookup, so different PCs may alias to one entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pcD[PC_W-1:IDX_W+2], pcD[1:0],
                            pcE[PC_W-1:IDX_W+2], pcE[1:0]};

  branch_hist_table #(.IDX_W(IDX_W)) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (pcD[IDX_W+1:2]),
    .rd_ctr   (rd_ctr),
    .wr_en    (branchE),
    .wr_idx   (pcE[IDX_W+1:2]),
    .wr_taken (takenE)
  );

  assign predtakenD  = branchD & rd_ctr[1];
  assign mispredictE = branchE & (takenE ^ predtakenE);

  // E-stage recovery outranks any D-stage prediction, stalled or not.
  always_comb begin
    brmuxsel = BRSEL_SEQ;
    flushD   = 1'b0;
    if (mispredictE) begin
      brmuxsel = takenE ? BRSEL_RECT : BRSEL_RECNT;
      flushD   = 1'b1;
    end else if (predtakenD && !stallD) begin
      brmuxsel = BRSEL_PRED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misscount <= '0;
    end else if (clr_misscount) begin
      misscount <= '0;
    end else if (mispredictE && (misscount != {MISS_W{1'b1}})) begin
      misscount <= misscount + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: expected outputs are queued as
// each cycle is driven, observed outputs are captured at the falling edge.
module tb_branch_predict_ctrl;

  localparam int PC_W   = 32;
  localparam int IDX_W  = 6;
  localparam int MW     = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            branchD, stallD, branchE, takenE, predtakenE, clr_misscount;
  logic [PC_W-1:0] pcD, pcE;
  logic            predtakenD, flushD, mispredictE;
  logic [1:0]      brmuxsel;
  logic [MW-1:0]   misscount;

  typedef struct packed {
    logic          pt;
    logic [1:0]    sel;
    logic          fl;
    logic          mp;
    logic [MW-1:0] mc;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_predict_ctrl #(.PC_W(PC_W), .IDX_W(IDX_W), .MISS_W(MW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .branchD       (branchD),
    .pcD           (pcD),
    .stallD        (stallD),
    .branchE       (branchE),
    .pcE           (pcE),
    .takenE        (takenE),
    .predtakenE    (predtakenE),
    .predtakenD    (predtakenD),
    .brmuxsel      (brmuxsel),
    .flushD        (flushD),
    .mispredictE   (mispredictE),
    .misscount     (misscount),
    .clr_misscount (clr_misscount)
  );

  function automatic obs_t mk(input logic pt, input logic [1:0] sel,
                              input logic fl, input logic mp, input int mc);
    obs_t o;
    o.pt = pt; o.sel = sel; o.fl = fl; o.mp = mp; o.mc = mc[MW-1:0];
    return o;
  endfunction

  task automatic capture();
    obs_q.push_back({predtakenD, brmuxsel, flushD, mispredictE, misscount});
  endtask

  // One pipeline cycle: drive after the rising edge, capture at the falling edge.
  task automatic cyc(input logic bd, input logic [PC_W-1:0] pd, input logic sd,
                     input logic be, input logic [PC_W-1:0] pe, input logic te,
                     input logic pte, input logic clr);
    branchD = bd; pcD = pd; stallD = sd; branchE = be; pcE = pe;
    takenE = te; predtakenE = pte; clr_misscount = clr;
    @(negedge clk);
    capture();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    branchD = 1'b1; pcD = 32'h40; stallD = 1'b0; branchE = 1'b0; pcE = '0;
    takenE = 1'b0; predtakenE = 1'b0; clr_misscount = 1'b0;
    #12;
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    capture();
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset: got pt=%b sel=%0d fl=%b mp=%b mc=%0d expected pt=%b sel=%0d fl=%b mp=%b mc=%0d",
                 o.pt, o.sel, o.fl, o.mp, o.mc, e.pt, e.sel, e.fl, e.mp, e.mc);
      end
    end
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_train();
    exp_q.push_back(mk(0, 0, 0, 0, 0)); cyc(1, 32'h40, 0, 0, 0, 0, 0, 0);       // entry 01
    exp_q.push_back(mk(0, 3, 1, 1, 0)); cyc(0, 0, 0, 1, 32'h40, 1, 0, 0);       // -> 10
    exp_q.push_back(mk(0, 3, 1, 1, 1)); cyc(0, 0, 0, 1, 32'h40, 1, 0, 0);       // -> 11
    exp_q.push_back(mk(1, 1, 0, 0, 2)); cyc(1, 32'h40, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(0, 0, 0, 0, 2)); cyc(0, 0, 0, 1, 32'h40, 1, 1, 0);     // saturates at 11
    end
    exp_q.push_back(mk(0, 2, 1, 1, 2)); cyc(0, 0, 0, 1, 32'h40, 0, 1, 0);       // -> 10
    exp_q.push_back(mk(1, 1, 0, 0, 3)); cyc(1, 32'h40, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 0, 0, 3)); cyc(1, 32'h40, 1, 0, 0, 0, 0, 0);       // stalled D
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL train: got pt=%b sel=%0d fl=%b mp=%b mc=%0d expected pt=%b sel=%0d fl=%b mp=%b mc=%0d",
                 o.pt, o.sel, o.fl, o.mp, o.mc, e.pt, e.sel, e.fl, e.mp, e.mc);
      end
    end
  endtask

  task automatic test_override();
    exp_q.push_back(mk(1, 2, 1, 1, 3)); cyc(1, 32'h40, 0, 1, 32'h100, 0, 1, 0);
    exp_q.push_back(mk(1, 3, 1, 1, 4)); cyc(1, 32'h40, 1, 1, 32'h104, 1, 0, 0);
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL override: got pt=%b sel=%0d fl=%b mp=%b mc=%0d expected pt=%b sel=%0d fl=%b mp=%b mc=%0d",
                 o.pt, o.sel, o.fl, o.mp, o.mc, e.pt, e.sel, e.fl, e.mp, e.mc);
      end
    end
  endtask

  task automatic test_same_index();
    exp_q.push_back(mk(0, 0, 0, 0, 5)); cyc(1, 32'h80, 0, 1, 32'h80, 1, 1, 0);
    exp_q.push_back(mk(1, 1, 0, 0, 5)); cyc(1, 32'h80, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(mk(1, 1, 0, 0, 5)); cyc(1, 32'h140, 0, 0, 0, 0, 0, 0);      // aliases 0x40
    exp_q.push_back(mk(0, 0, 0, 0, 5)); cyc(0, 32'h40, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL same_index: got pt=%b sel=%0d fl=%b mp=%b mc=%0d expected pt=%b sel=%0d fl=%b mp=%b mc=%0d",
                 o.pt, o.sel, o.fl, o.mp, o.mc, e.pt, e.sel, e.fl, e.mp, e.mc);
      end
    end
  endtask

  task automatic test_misscount();
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(mk(0, 3, 1, 1, (5 + i > 15) ? 15 : 5 + i));
      cyc(0, 0, 0, 1, 32'h200, 1, 0, 0);
    end
    exp_q.push_back(mk(0, 3, 1, 1, 15)); cyc(0, 0, 0, 1, 32'h200, 1, 0, 1);    // clear wins
    exp_q.push_back(mk(0, 0, 0, 0, 0));  cyc(0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(mk(0, 2, 1, 1, 0));  cyc(0, 0, 0, 1, 32'h200, 0, 1, 0);
    exp_q.push_back(mk(0, 0, 0, 0, 1));  cyc(0, 0, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL misscount: got pt=%b sel=%0d fl=%b mp=%b mc=%0d expected pt=%b sel=%0d fl=%b mp=%b mc=%0d",
                 o.pt, o.sel, o.fl, o.mp, o.mc, e.pt, e.sel, e.fl, e.mp, e.mc);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_q.push_back(mk(1, 3, 1, 1, 1)); cyc(1, 32'h40, 0, 1, 32'h300, 1, 0, 0);
    // Reset lands mid-cycle with a correct-prediction update pending at 0x40.
    branchD = 1'b1; pcD = 32'h40; stallD = 1'b0; branchE = 1'b1; pcE = 32'h40;
    takenE = 1'b1; predtakenE = 1'b1; clr_misscount = 1'b0;
    #2 rst_n = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    @(negedge clk);
    capture();
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0)); cyc(1, 32'h40, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(mk(0, 0, 0, 0, 0)); cyc(1, 32'h80, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid: got pt=%b sel=%0d fl=%b mp=%b mc=%0d expected pt=%b sel=%0d fl=%b mp=%b mc=%0d",
                 o.pt, o.sel, o.fl, o.mp, o.mc, e.pt, e.sel, e.fl, e.mp, e.mc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_train();
    test_override();
    test_same_index();
    test_misscount();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
